uart_rx_byte: RTL

UART byte receiver, the receive-side counterpart of `uart_tx_I`, with the same baud-select encoding and 8N1 framing. It sits between the `rs232_rx` pin and the on-chip data path, for example the DPRAM write side in `uart_dpram`. It oversamples the line 16x, takes a majority vote at mid-bit, and delivers each byte with a one-cycle `rx_done` strobe. Frames that fail validation are reported with a one-cycle `frame_err` strobe.

---
 rtl/uart_rx_byte_pkg.sv | 43 ++++
 rtl/uart_rx_byte_if.sv | 19 +
 rtl/uart_bps_gen.sv | 31 +++
 rtl/uart_rx_byte.sv | 121 ++++++++++++
 4 files changed

// File: rtl/uart_rx_byte_pkg.sv
// Shared UART definitions: baud-select codes, divisor table and FSM state encoding,
// common to the receiver and the transmitter.
package uart_rx_byte_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    typedef enum logic [2:0] {
        BAUD_9600   = 3'd0,
        BAUD_19200  = 3'd1,
        BAUD_38400  = 3'd2,
        BAUD_57600  = 3'd3,
        BAUD_115200 = 3'd4
    } baud_sel_t;

    localparam int unsigned DIV_W        = 16;
    localparam int unsigned REF_CLK_FREQ = 50_000_000;

    // 16x oversample divisors at the 50 MHz reference clock.
    localparam int unsigned BPS_DR_9600   = 325;
    localparam int unsigned BPS_DR_19200  = 163;
    localparam int unsigned BPS_DR_38400  = 81;
    localparam int unsigned BPS_DR_57600  = 54;
    localparam int unsigned BPS_DR_115200 = 27;

    // Codes 5-7 fall back to 9600; other clock rates scale the reference table.
    function automatic logic [DIV_W-1:0] bps_div(input logic [2:0] sel, input int unsigned clk_freq);
        logic [63:0] base;
        case (sel)
            BAUD_19200:  base = 64'(BPS_DR_19200);
            BAUD_38400:  base = 64'(BPS_DR_38400);
            BAUD_57600:  base = 64'(BPS_DR_57600);
            BAUD_115200: base = 64'(BPS_DR_115200);
            default:     base = 64'(BPS_DR_9600);
        endcase
        return DIV_W'(base * 64'(clk_freq) / 64'(REF_CLK_FREQ));
    endfunction

endpackage

// File: rtl/uart_rx_byte_if.sv
// Receiver-side bundle: serial line and baud select in, byte and status strobes out.
interface uart_rx_byte_if;
    logic [2:0] baud_set;
    logic       rs232_rx;
    logic [7:0] data_byte;
    logic       rx_done;
    logic       frame_err;
    logic       uart_state;

    modport master (
        input  baud_set, rs232_rx,
        output data_byte, rx_done, frame_err, uart_state
    );

    modport slave (
        output baud_set, rs232_rx,
        input  data_byte, rx_done, frame_err, uart_state
    );
endinterface

// File: rtl/uart_bps_gen.sv
// Oversample tick generator: one-cycle tick every D clocks, counter held at zero
// while disabled so the tick phase aligns to the enable edge.
module uart_bps_gen
    import uart_rx_byte_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [2:0] baud_set,
    output logic       tick
);
    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] cnt;

    always_comb begin
        div  = bps_div(baud_set, CLK_FREQ);
        tick = en && (cnt == div - DIV_W'(1));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (!en || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + DIV_W'(1);
        end
    end
endmodule

// File: rtl/uart_rx_byte.sv
// UART 8N1 byte receiver: 16x oversampling, 3-sample majority vote at mid-bit,
// one-cycle rx_done / frame_err strobes.
module uart_rx_byte
    import uart_rx_byte_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 50_000_000
) (
    input  logic           clk,
    input  logic           rst,
    uart_rx_byte_if.master bus
);
    rx_state_t  state, state_next;
    logic       sync1, sync2, sync3;
    logic [1:0] flush;
    logic       armed, fall;
    logic [2:0] baud_q;
    logic       tick, busy, mid_tick, maj;
    logic [3:0] sub, bitn;
    logic       vote6, vote7;
    logic [7:0] shift;
    logic       shift_en, done_next, err_next;
    logic [7:0] data_q;
    logic       done_q, err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            sync3 <= 1'b1;
            flush <= '0;
            armed <= 1'b0;
        end else begin
            sync1 <= bus.rs232_rx;
            sync2 <= sync1;
            sync3 <= sync2;
            flush <= {flush[0], 1'b1};
            armed <= armed | (flush[1] & sync2);
        end
    end

    // Edges count only once the synchroniser has held a real high sample, so a
    // line held low through reset release cannot fake a start bit.
    always_comb begin
        fall     = armed & sync3 & ~sync2;
        mid_tick = tick && (sub == 4'd8);
        maj      = (vote6 & vote7) | (vote6 & sync2) | (vote7 & sync2);
    end

    uart_bps_gen #(.CLK_FREQ(CLK_FREQ)) bps_gen (
        .clk      (clk),
        .rst      (rst),
        .en       (busy),
        .baud_set (baud_q),
        .tick     (tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (fall) state_next = START;
            START: begin
                if (mid_tick && maj) begin
                    state_next = IDLE;
                end else if (tick && sub == 4'd15) begin
                    state_next = DATA;
                end
            end
            DATA:  if (tick && sub == 4'd15 && bitn == 4'd8) state_next = STOP;
            STOP:  if (mid_tick) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy           = (state != IDLE);
        shift_en       = (state == DATA) && mid_tick;
        done_next      = (state == STOP) && mid_tick && maj;
        err_next       = (state == STOP) && mid_tick && !maj;
        bus.uart_state = busy;
        bus.data_byte  = data_q;
        bus.rx_done    = done_q;
        bus.frame_err  = err_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            baud_q <= '0;
            sub    <= '0;
            bitn   <= '0;
            vote6  <= 1'b0;
            vote7  <= 1'b0;
            shift  <= '0;
            data_q <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            done_q <= done_next;
            err_q  <= err_next;
            if (done_next) data_q <= shift;
            if (state == IDLE) begin
                sub  <= '0;
                bitn <= '0;
                if (fall) baud_q <= bus.baud_set;
            end else if (tick) begin
                sub <= sub + 4'd1;
                if (sub == 4'd15) bitn <= bitn + 4'd1;
                if (sub == 4'd6) vote6 <= sync2;
                if (sub == 4'd7) vote7 <= sync2;
            end
            if (shift_en) shift <= {maj, shift[7:1]};
        end
    end
endmodule
